// File: rtl/uart_cmd_controller.sv
// Sequences a {command, address} UART frame into a sensor req/ack transaction and
// returns the {code, data} reply to the UART transmitter one byte at a time.
module uart_cmd_controller #(
  parameter int unsigned TIMEOUT_CYCLES   = 230400,
  parameter int unsigned INTERBYTE_CYCLES = 11520,
  parameter int unsigned MAX_ADDR         = 31
) (
  input  logic       clk_115200hz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_control,
  output logic       sens_req,
  output logic [1:0] sens_cmd,
  output logic [4:0] sens_addr,
  input  logic       sens_ack,
  input  logic [7:0] sens_data,
  input  logic       sens_err,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy
);

  typedef enum logic [3:0] {
    StIdle, StGetAddr, StCheck, StReq, StWaitAck, StSend1, StWait1, StSend2, StWait2
  } state_e;

  localparam logic [23:0] IbLast  = 24'(INTERBYTE_CYCLES - 1);
  localparam logic [23:0] ToLast  = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  MaxAddr = 8'(MAX_ADDR);

  state_e      state_q, state_d;
  logic        rx_prev_q;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d, addr_q, addr_d;
  logic [7:0]  code_q, code_d, data_q, data_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        sens_req_q, sens_req_d;
  logic [1:0]  sens_cmd_q, sens_cmd_d;
  logic [4:0]  sens_addr_q, sens_addr_d;
  logic        rx_event, frame_ok;

  assign rx_event = rx_control & ~rx_prev_q;
  assign frame_ok = (cmd_q >= 8'd1) && (cmd_q <= 8'd3) && (addr_q <= MaxAddr);

  always_ff @(posedge clk_115200hz) begin
    if (reset) begin
      state_q     <= StIdle;
      rx_prev_q   <= 1'b0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      code_q      <= '0;
      data_q      <= '0;
      tx_data_q   <= '0;
      sens_req_q  <= 1'b0;
      sens_cmd_q  <= '0;
      sens_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rx_prev_q   <= rx_control;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      code_q      <= code_d;
      data_q      <= data_d;
      tx_data_q   <= tx_data_d;
      sens_req_q  <= sens_req_d;
      sens_cmd_q  <= sens_cmd_d;
      sens_addr_q <= sens_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    code_d      = code_q;
    data_d      = data_q;
    tx_data_d   = tx_data_q;
    sens_req_d  = sens_req_q;
    sens_cmd_d  = sens_cmd_q;
    sens_addr_d = sens_addr_q;
    tx_start    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_event) begin
          cmd_d   = rx_data;
          cnt_d   = '0;
          state_d = StGetAddr;
        end
      end
      StGetAddr: begin
        if (rx_event) begin
          addr_d  = rx_data;
          state_d = StCheck;
        end else if (cnt_q == IbLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      StCheck: begin
        if (frame_ok) begin
          state_d = StReq;
        end else begin
          code_d  = 8'hEE;
          data_d  = 8'h00;
          state_d = StSend1;
        end
      end
      StReq: begin
        sens_req_d  = 1'b1;
        sens_cmd_d  = cmd_q[1:0];
        sens_addr_d = addr_q[4:0];
        cnt_d       = '0;
        state_d     = StWaitAck;
      end
      StWaitAck: begin
        // An ack arriving in the expiry cycle still yields a normal reply.
        if (sens_ack) begin
          sens_req_d = 1'b0;
          code_d     = sens_err ? 8'h1F : {6'b000010, cmd_q[1:0]};
          data_d     = sens_err ? 8'h00 : sens_data;
          state_d    = StSend1;
        end else if (cnt_q == ToLast) begin
          sens_req_d = 1'b0;
          code_d     = 8'hFD;
          data_d     = 8'h00;
          state_d    = StSend1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      StSend1, StSend2: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data_d = (state_q == StSend1) ? code_q : data_q;
          cnt_d     = '0;
          state_d   = (state_q == StSend1) ? StWait1 : StWait2;
        end
      end
      StWait1, StWait2: begin
        // The transmitter may not raise tx_busy until a cycle after tx_start.
        if (cnt_q == '0) begin
          cnt_d = 24'd1;
        end else if (!tx_busy) begin
          cnt_d   = '0;
          state_d = (state_q == StWait1) ? StSend2 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tx_data   = (state_q == StSend1) ? code_q :
                     (state_q == StSend2) ? data_q : tx_data_q;
  assign sens_req  = sens_req_q;
  assign sens_cmd  = sens_cmd_q;
  assign sens_addr = sens_addr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Directed bench for uart_cmd_controller with a small transmitter model and tx byte monitor.
module tb_uart_cmd_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_control = 1'b0;
  logic       sens_req;
  logic [1:0] sens_cmd;
  logic [4:0] sens_addr;
  logic       sens_ack = 1'b0;
  logic [7:0] sens_data = '0;
  logic       sens_err = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       hold_busy = 1'b0;
  int         tx_cnt = 0;

  int n_cmp = 0;
  int n_err = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  logic [7:0] txq[$];

  uart_cmd_controller #(
    .TIMEOUT_CYCLES  (100),
    .INTERBYTE_CYCLES(50),
    .MAX_ADDR        (31)
  ) dut (
    .clk_115200hz(clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_control  (rx_control),
    .sens_req    (sens_req),
    .sens_cmd    (sens_cmd),
    .sens_addr   (sens_addr),
    .sens_ack    (sens_ack),
    .sens_data   (sens_data),
    .sens_err    (sens_err),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for 5 cycles after each start, or while forced.
  always @(posedge clk) begin
    if (tx_start) tx_cnt <= 5;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_busy = (tx_cnt != 0) || hold_busy;

  always @(negedge clk) begin
    if (tx_start) txq.push_back(tx_data);
    if (sens_req && !req_prev) req_rises++;
    req_prev = sens_req;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data    = b;
    rx_control = 1'b1;
    tick(1);
    rx_control = 1'b0;
  endtask

  // Returns at the negedge right after the edge that detected byte 2.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a);
    send_byte(c);
    tick(1);
    send_byte(a);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    chk("return_to_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic ack(input logic [7:0] d, input logic e);
    sens_ack  = 1'b1;
    sens_data = d;
    sens_err  = e;
    tick(1);
    sens_ack  = 1'b0;
    sens_data = '0;
    sens_err  = 1'b0;
  endtask

  initial begin
    int rises0;
    int held;

    // 1: reset with rx_control toggling
    tick(1);
    for (int i = 0; i < 5; i++) begin
      rx_control = i[0];
      rx_data    = 8'h01;
      tick(1);
      chk("rst_outputs", {tx_start, sens_req, busy, sens_cmd, sens_addr, tx_data}, 32'd0);
    end
    reset = 1'b0;
    tick(5);
    chk("post_rst_req", {31'd0, sens_req}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // 2: temperature read at address 5
    txq.delete();
    send_frame(8'h02, 8'h05);
    chk("req_lat_e0", {31'd0, sens_req}, 32'd0);
    tick(1);
    chk("req_lat_e1", {31'd0, sens_req}, 32'd0);
    tick(1);
    chk("req_lat_e2", {31'd0, sens_req}, 32'd1);
    chk("req_cmd", {30'd0, sens_cmd}, 32'd2);
    chk("req_addr", {27'd0, sens_addr}, 32'd5);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("req_held", {29'd0, sens_req, sens_cmd}, 32'h6);
    end
    ack(8'h19, 1'b0);
    chk("req_drop", {31'd0, sens_req}, 32'd0);
    chk("reply_start_lat", {31'd0, tx_start}, 32'd1);
    chk("reply_code_now", {24'd0, tx_data}, 32'h0A);
    wait_idle();
    chk("t2_tx_count", txq.size(), 32'd2);
    if (txq.size() == 2) begin
      chk("t2_tx0", {24'd0, txq[0]}, 32'h0A);
      chk("t2_tx1", {24'd0, txq[1]}, 32'h19);
    end
    chk("tx_data_hold", {24'd0, tx_data}, 32'h19);

    // 3: bad command, then out-of-range address
    rises0 = req_rises;
    txq.delete();
    send_frame(8'h07, 8'h03);
    tick(1);
    chk("badcmd_start", {23'd0, tx_start, tx_data}, 32'h1EE);
    wait_idle();
    send_frame(8'h01, 8'h20);
    wait_idle();
    chk("bad_tx_count", txq.size(), 32'd4);
    if (txq.size() == 4) begin
      chk("bad_tx", {txq[0], txq[1], txq[2], txq[3]}, 32'hEE00EE00);
    end
    chk("bad_no_req", req_rises, rises0);

    // 4: timeout, then ack in the expiry cycle
    txq.delete();
    send_frame(8'h01, 8'h00);
    tick(2);
    held = 0;
    while (sens_req && held < 300) begin
      held++;
      tick(1);
    end
    chk("timeout_len", held, 32'd100);
    chk("timeout_start", {23'd0, tx_start, tx_data}, 32'h1FD);
    wait_idle();
    chk("timeout_tx_count", txq.size(), 32'd2);
    if (txq.size() == 2) chk("timeout_tx", {16'd0, txq[0], txq[1]}, 32'hFD00);
    txq.delete();
    send_frame(8'h01, 8'h00);
    tick(2);
    tick(99);
    chk("late_req_high", {31'd0, sens_req}, 32'd1);
    ack(8'h55, 1'b0);
    chk("late_ack_start", {23'd0, tx_start, tx_data}, 32'h109);
    wait_idle();
    if (txq.size() == 2) chk("late_ack_tx", {16'd0, txq[0], txq[1]}, 32'h0955);
    else chk("late_ack_tx_count", txq.size(), 32'd2);

    // 5: interbyte timeout discards the first byte
    txq.delete();
    send_byte(8'h01);
    tick(49);
    chk("ib_busy_before", {31'd0, busy}, 32'd1);
    tick(1);
    chk("ib_discard", {31'd0, busy}, 32'd0);
    tick(10);
    send_frame(8'h02, 8'h03);
    tick(2);
    chk("ib_req", {26'd0, sens_req, sens_cmd, 3'd0}, {26'd0, 1'b1, 2'd2, 3'd0});
    chk("ib_addr", {27'd0, sens_addr}, 32'd3);
    ack(8'h33, 1'b0);
    wait_idle();
    if (txq.size() == 2) chk("ib_tx", {16'd0, txq[0], txq[1]}, 32'h0A33);
    else chk("ib_tx_count", txq.size(), 32'd2);

    // 6a: byte during WAIT_ACK dropped; sensor error reply
    txq.delete();
    send_frame(8'h03, 8'h07);
    tick(3);
    send_byte(8'h01);
    tick(3);
    chk("drop_req_cmd", {29'd0, sens_req, sens_cmd}, 32'h7);
    ack(8'h44, 1'b1);
    wait_idle();
    tick(5);
    chk("drop_stays_idle", {31'd0, busy}, 32'd0);
    if (txq.size() == 2) chk("err_tx", {16'd0, txq[0], txq[1]}, 32'h1F00);
    else chk("err_tx_count", txq.size(), 32'd2);

    // 6b: reset while waiting for ack
    txq.delete();
    send_frame(8'h01, 8'h02);
    tick(5);
    chk("rst_mid_req", {31'd0, sens_req}, 32'd1);
    reset = 1'b1;
    tick(1);
    chk("rst_mid_out", {29'd0, sens_req, tx_start, busy}, 32'd0);
    reset = 1'b0;
    tick(5);
    chk("rst_mid_no_tx", txq.size(), 32'd0);

    // 6c: tx_busy held at SEND1 delays the start
    txq.delete();
    send_frame(8'h02, 8'h01);
    tick(4);
    hold_busy = 1'b1;
    ack(8'h21, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("held_no_start", {30'd0, tx_start, busy}, 32'd1);
      tick(1);
    end
    @(posedge clk);
    #1 hold_busy = 1'b0;
    #1 chk("release_start", {23'd0, tx_start, tx_data}, 32'h10A);
    wait_idle();
    if (txq.size() == 2) chk("held_tx", {16'd0, txq[0], txq[1]}, 32'h0A21);
    else chk("held_tx_count", txq.size(), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
